// File: rtl/vdp_timing_gen.sv
// Mega Drive VDP-style raster timing source: pixel strobe, pixel clock, enables, syncs and field.
// Define VDP_TIMING_PATTERN_EN to drive 8 vertical colour bars; otherwise r/g/b_out are tied to 0.
module vdp_timing_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       h40,
  input  logic       v30,
  input  logic       pal,
  input  logic       lace,
  output logic       ce_pix,
  output logic       vdp_hclk1,
  output logic       vdp_de_h,
  output logic       vdp_de_v,
  output logic       vdp_intfield,
  output logic       hs_out,
  output logic       vs_out,
  output logic [8:0] pix_x,
  output logic [8:0] line_y,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out
);

  logic       started_q, started_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic [8:0] hpos_q, hpos_d;
  logic [8:0] vpos_q, vpos_d;
  logic       h40_q, h40_d, v30_q, v30_d, pal_q, pal_d, lace_q, lace_d;
  logic       field_q, field_d;

  logic       ce_pix_q, ce_pix_d;
  logic       hclk1_q, hclk1_d;
  logic       de_h_q, de_h_d, de_v_q, de_v_d;
  logic       intfield_q, intfield_d;
  logic       hs_q, hs_d, vs_q, vs_d;
  logic [8:0] pix_x_q, pix_x_d, line_y_q, line_y_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic [3:0] last_dcnt, half;
  logic [8:0] last_slot, frame_last, act_w, act_h, vs_start;
  logic       emit, line_end, frame_end, hs_lo, vs_lo, act_h_now, act_v_now;
  logic [7:0] pat_r, pat_g, pat_b;

  always_comb begin
    half      = h40_q ? 4'd4 : 4'd5;
    last_slot = h40_q ? 9'd426 : 9'd341;
    // The last H40 slot is stretched by 4 pad clocks so every line is 3420 clocks.
    if (!h40_q)                  last_dcnt = 4'd9;
    else if (hpos_q == 9'd426)   last_dcnt = 4'd11;
    else                         last_dcnt = 4'd7;
    act_w = h40_q ? 9'd320 : 9'd256;
    act_h = v30_q ? 9'd240 : 9'd224;
    if (!pal_q)      vs_start = act_h + 9'd10;
    else if (v30_q)  vs_start = 9'd267;
    else             vs_start = 9'd259;
    frame_last = (pal_q ? 9'd312 : 9'd261) + {8'd0, lace_q & field_q};
    emit       = started_q & (dcnt_q == 4'd0);
    line_end   = started_q & (dcnt_q == last_dcnt) & (hpos_q == last_slot);
    frame_end  = line_end & (vpos_q == frame_last);
    hs_lo      = h40_q ? (hpos_q >= 9'd332 && hpos_q <= 9'd363)
                       : (hpos_q >= 9'd265 && hpos_q <= 9'd290);
    vs_lo      = (vpos_q >= vs_start) && (vpos_q < vs_start + 9'd3);
    act_h_now  = hpos_q < act_w;
    act_v_now  = vpos_q < act_h;
  end

`ifdef VDP_TIMING_PATTERN_EN
  logic [2:0] bar;
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hpos_q >= (h40_q ? 9'(40 * k) : 9'(32 * k))) bar = 3'(k);
    end
    // Bar index 0..7 maps to white, yellow, cyan, green, magenta, red, blue, black.
    pat_r = {8{~bar[1]}};
    pat_g = {8{~bar[2]}};
    pat_b = {8{~bar[0]}};
  end
`else
  always_comb begin
    pat_r = 8'd0;
    pat_g = 8'd0;
    pat_b = 8'd0;
  end
`endif

  always_comb begin
    started_d  = 1'b1;
    dcnt_d     = dcnt_q;
    hpos_d     = hpos_q;
    vpos_d     = vpos_q;
    h40_d      = h40_q;
    v30_d      = v30_q;
    pal_d      = pal_q;
    lace_d     = lace_q;
    field_d    = field_q;
    ce_pix_d   = emit;
    hclk1_d    = started_q & (dcnt_q < half);
    de_h_d     = de_h_q;
    de_v_d     = de_v_q;
    intfield_d = intfield_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    pix_x_d    = pix_x_q;
    line_y_d   = line_y_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;

    if (!started_q) begin
      h40_d  = h40;
      v30_d  = v30;
      pal_d  = pal;
      lace_d = lace;
    end else if (dcnt_q == last_dcnt) begin
      dcnt_d = 4'd0;
      if (line_end) begin
        hpos_d = 9'd0;
        if (frame_end) begin
          vpos_d  = 9'd0;
          h40_d   = h40;
          v30_d   = v30;
          pal_d   = pal;
          lace_d  = lace;
          field_d = lace ? ~field_q : 1'b0;
        end else begin
          vpos_d = vpos_q + 9'd1;
        end
      end else begin
        hpos_d = hpos_q + 9'd1;
      end
    end else begin
      dcnt_d = dcnt_q + 4'd1;
    end

    if (emit) begin
      pix_x_d    = hpos_q;
      line_y_d   = vpos_q;
      de_h_d     = act_h_now;
      de_v_d     = act_v_now;
      intfield_d = field_q;
      hs_d       = ~hs_lo;
      vs_d       = ~vs_lo;
      r_d        = (act_h_now & act_v_now) ? pat_r : 8'd0;
      g_d        = (act_h_now & act_v_now) ? pat_g : 8'd0;
      b_d        = (act_h_now & act_v_now) ? pat_b : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started_q  <= 1'b0;
      dcnt_q     <= 4'd0;
      hpos_q     <= 9'd0;
      vpos_q     <= 9'd0;
      h40_q      <= 1'b0;
      v30_q      <= 1'b0;
      pal_q      <= 1'b0;
      lace_q     <= 1'b0;
      field_q    <= 1'b0;
      ce_pix_q   <= 1'b0;
      hclk1_q    <= 1'b0;
      de_h_q     <= 1'b0;
      de_v_q     <= 1'b0;
      intfield_q <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      pix_x_q    <= 9'd0;
      line_y_q   <= 9'd0;
      r_q        <= 8'd0;
      g_q        <= 8'd0;
      b_q        <= 8'd0;
    end else begin
      started_q  <= started_d;
      dcnt_q     <= dcnt_d;
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
      h40_q      <= h40_d;
      v30_q      <= v30_d;
      pal_q      <= pal_d;
      lace_q     <= lace_d;
      field_q    <= field_d;
      ce_pix_q   <= ce_pix_d;
      hclk1_q    <= hclk1_d;
      de_h_q     <= de_h_d;
      de_v_q     <= de_v_d;
      intfield_q <= intfield_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      pix_x_q    <= pix_x_d;
      line_y_q   <= line_y_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign ce_pix       = ce_pix_q;
  assign vdp_hclk1    = hclk1_q;
  assign vdp_de_h     = de_h_q;
  assign vdp_de_v     = de_v_q;
  assign vdp_intfield = intfield_q;
  assign hs_out       = hs_q;
  assign vs_out       = vs_q;
  assign pix_x        = pix_x_q;
  assign line_y       = line_y_q;
  assign r_out        = r_q;
  assign g_out        = g_q;
  assign b_out        = b_q;

endmodule
